// File: rtl/event_counter_updown.sv
// Up/down event counter with programmable modulo, wrap/saturate mode, clear/load
// and boundary flags; asynchronous up/down inputs are synchronised, debounced and edge-detected.

module ecu_input #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic din,
  output logic evt
);
  logic [SYNC_STAGES-1:0] sync;
  logic                   filt;
  logic                   filt_dly;

  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) sync <= '0;
    else         sync <= {sync[SYNC_STAGES-2:0], din};

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_nodb
      assign filt = sync[SYNC_STAGES-1];
    end else begin : g_db
      localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
      logic [DW-1:0] db_cnt;
      logic          filt_q;

      // A new level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
      always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i) begin
          db_cnt <= '0;
          filt_q <= 1'b0;
        end else if (sync[SYNC_STAGES-1] == filt_q) begin
          db_cnt <= '0;
        end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          filt_q <= sync[SYNC_STAGES-1];
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DW'(1);
        end

      assign filt = filt_q;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) filt_dly <= 1'b0;
    else         filt_dly <= filt;

  assign evt = filt & ~filt_dly;
endmodule

module event_counter_updown #(
  parameter int          COUNT_WIDTH     = 16,
  parameter int unsigned MAX_VALUE       = 2**COUNT_WIDTH - 1,
  parameter bit          SATURATE        = 1'b0,
  parameter int          SYNC_STAGES     = 2,
  parameter int          DEBOUNCE_CYCLES = 0
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   up_i,
  input  logic                   down_i,
  input  logic                   clear_i,
  input  logic                   load_i,
  input  logic [COUNT_WIDTH-1:0] load_val_i,
  output logic [COUNT_WIDTH-1:0] count_o,
  output logic                   wrap_o,
  output logic                   at_max_o,
  output logic                   at_zero_o
);
  localparam logic [COUNT_WIDTH-1:0] MAXV = COUNT_WIDTH'(MAX_VALUE);

  logic [1:0] raw;
  logic [1:0] evt;
  logic       up_ev;
  logic       dn_ev;

  assign raw = {down_i, up_i};

  for (genvar g = 0; g < 2; g++) begin : g_in
    ecu_input #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_in (
      .clk_i (clk_i),
      .rstn_i(rstn_i),
      .din   (raw[g]),
      .evt   (evt[g])
    );
  end

  assign up_ev = evt[0];
  assign dn_ev = evt[1];

  // Clear and load take precedence; any event landing in that cycle is lost.
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      count_o <= '0;
      wrap_o  <= 1'b0;
    end else begin
      wrap_o <= 1'b0;
      if (clear_i) begin
        count_o <= '0;
      end else if (load_i) begin
        count_o <= (load_val_i > MAXV) ? MAXV : load_val_i;
      end else if (up_ev && !dn_ev) begin
        if (count_o != MAXV) begin
          count_o <= count_o + COUNT_WIDTH'(1);
        end else if (!SATURATE) begin
          count_o <= '0;
          wrap_o  <= 1'b1;
        end
      end else if (dn_ev && !up_ev) begin
        if (count_o != '0) begin
          count_o <= count_o - COUNT_WIDTH'(1);
        end else if (!SATURATE) begin
          count_o <= MAXV;
          wrap_o  <= 1'b1;
        end
      end
    end

  assign at_max_o  = (count_o == MAXV);
  assign at_zero_o = (count_o == '0);
endmodule

// File: tb/tb_event_counter_updown.sv
// Drives three counter variants (wrap, saturate, debounced) from shared stimulus and
// compares each against a history-based reference model every cycle.

module tb_event_counter_updown;
  logic clk = 1'b0, rstn = 1'b0, up = 1'b0, down = 1'b0, clear = 1'b0, load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [2:0][3:0] cnt;
  logic [2:0] wrp, amax, azero;
  int chk = 0, err = 0;

  always #5 clk = ~clk;

  event_counter_updown #(.COUNT_WIDTH(4), .MAX_VALUE(9), .SATURATE(1'b0), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0)) dut_w (
    .clk_i(clk), .rstn_i(rstn), .up_i(up), .down_i(down), .clear_i(clear), .load_i(load), .load_val_i(load_val),
    .count_o(cnt[0]), .wrap_o(wrp[0]), .at_max_o(amax[0]), .at_zero_o(azero[0]));
  event_counter_updown #(.COUNT_WIDTH(4), .MAX_VALUE(9), .SATURATE(1'b1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0)) dut_s (
    .clk_i(clk), .rstn_i(rstn), .up_i(up), .down_i(down), .clear_i(clear), .load_i(load), .load_val_i(load_val),
    .count_o(cnt[1]), .wrap_o(wrp[1]), .at_max_o(amax[1]), .at_zero_o(azero[1]));
  event_counter_updown #(.COUNT_WIDTH(4), .MAX_VALUE(9), .SATURATE(1'b0), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut_d (
    .clk_i(clk), .rstn_i(rstn), .up_i(up), .down_i(down), .clear_i(clear), .load_i(load), .load_val_i(load_val),
    .count_o(cnt[2]), .wrap_o(wrp[2]), .at_max_o(amax[2]), .at_zero_o(azero[2]));

  // Reference model: per-edge input history; filtered level = last value seen stable for D samples.
  localparam int NC = 3, HL = 8192;
  bit su[HL], sd[HL];
  bit fu[NC][HL], fd[NC][HL];
  int t = 0;
  int ecnt[NC];
  bit ew[NC];

  function automatic int db_of(input int i); return (i == 2) ? 4 : 0; endfunction
  function automatic bit sat_of(input int i); return (i == 1); endfunction

  function automatic bit smp(input bit is_up, input int j);
    if (j < 1 || j >= HL) return 1'b0;
    return is_up ? su[j] : sd[j];
  endfunction

  function automatic bit flt(input int i, input bit is_up, input int j);
    if (j < 1 || j >= HL) return 1'b0;
    return is_up ? fu[i][j] : fd[i][j];
  endfunction

  function automatic bit flt_new(input int i, input bit is_up, input int j);
    bit cur;
    cur = flt(i, is_up, j - 1);
    if (db_of(i) == 0) return smp(is_up, j - 1);
    for (int k = 0; k < db_of(i); k++)
      if (smp(is_up, j - 2 - k) == cur) return cur;
    return ~cur;
  endfunction

  initial begin
    for (int i = 0; i < NC; i++) begin ecnt[i] = 0; ew[i] = 1'b0; end
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        t = 0;
        for (int i = 0; i < NC; i++) begin ecnt[i] = 0; ew[i] = 1'b0; end
      end else begin
        t++;
        if (t < HL) begin su[t] = up; sd[t] = down; end
        for (int i = 0; i < NC; i++) begin
          bit eu, ed;
          eu = flt(i, 1'b1, t - 1) & ~flt(i, 1'b1, t - 2);
          ed = flt(i, 1'b0, t - 1) & ~flt(i, 1'b0, t - 2);
          ew[i] = 1'b0;
          if (clear) ecnt[i] = 0;
          else if (load) ecnt[i] = (int'(load_val) > 9) ? 9 : int'(load_val);
          else if (eu && !ed) begin
            if (ecnt[i] < 9) ecnt[i]++;
            else if (!sat_of(i)) begin ecnt[i] = 0; ew[i] = 1'b1; end
          end else if (ed && !eu) begin
            if (ecnt[i] > 0) ecnt[i]--;
            else if (!sat_of(i)) begin ecnt[i] = 9; ew[i] = 1'b1; end
          end
          if (t < HL) begin fu[i][t] = flt_new(i, 1'b1, t); fd[i][t] = flt_new(i, 1'b0, t); end
        end
      end
    end
  end

  function automatic logic [20:0] exp_state();
    logic [2:0][3:0] c;
    logic [2:0] w, m, z;
    for (int i = 0; i < NC; i++) begin
      c[i] = 4'(ecnt[i]); w[i] = ew[i]; m[i] = (ecnt[i] == 9); z[i] = (ecnt[i] == 0);
    end
    return {c, w, m, z};
  endfunction

  function automatic logic [20:0] dut_state();
    return {cnt, wrp, amax, azero};
  endfunction

  typedef struct { bit u, d, c, l; logic [3:0] v; int n; } row_t;

  task automatic apply(input row_t r);
    up = r.u; down = r.d; clear = r.c; load = r.l; load_val = r.v;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    chk++;
    if (cnt !== 12'h000 || wrp !== 3'b000 || amax !== 3'b000 || azero !== 3'b111) begin
      err++; $display("FAIL reset_state got cnt=%h wrap=%b max=%b zero=%b want 000/000/000/111", cnt, wrp, amax, azero);
    end
    chk++;
    if (dut_state() !== exp_state()) begin err++; $display("FAIL reset_model got %h want %h", dut_state(), exp_state()); end
    rstn = 1'b1;
  endtask

  task automatic test_count_up();
    row_t seq[6] = '{'{1,0,0,0,4'd0,5}, '{0,0,0,0,4'd0,10}, '{1,0,0,0,4'd0,5},
                     '{0,0,0,0,4'd0,10}, '{1,0,0,0,4'd0,5}, '{0,0,0,0,4'd0,10}};
    int lat = 0, k = 0;
    foreach (seq[r]) begin
      apply(seq[r]);
      for (int n = 0; n < seq[r].n; n++) begin
        @(negedge clk); k++; chk++;
        if (dut_state() !== exp_state()) begin err++; $display("FAIL count_up_model cyc=%0d got %h want %h", k, dut_state(), exp_state()); end
        if (lat == 0 && cnt[0] != 4'd0) lat = k;
      end
    end
    chk++; if (lat != 3) begin err++; $display("FAIL count_up_latency got %0d want 3", lat); end
    chk++; if (cnt !== {4'd3, 4'd3, 4'd3}) begin err++; $display("FAIL count_up_final got %h want 333", cnt); end
    chk++; if (azero !== 3'b000) begin err++; $display("FAIL count_up_zero_flag got %b want 000", azero); end
  endtask

  task automatic test_wrap();
    row_t seq[10] = '{'{0,0,0,1,4'd9,1}, '{0,0,0,0,4'd0,3}, '{1,0,0,0,4'd0,5}, '{0,0,0,0,4'd0,10},
                      '{0,1,0,0,4'd0,5}, '{0,0,0,0,4'd0,10}, '{0,0,1,0,4'd0,1}, '{0,0,0,0,4'd0,2},
                      '{0,1,0,0,4'd0,5}, '{0,0,0,0,4'd0,10}};
    logic [2:0][3:0] snap[10];
    int wc0 = 0, wc1 = 0, k = 0;
    foreach (seq[r]) begin
      apply(seq[r]);
      for (int n = 0; n < seq[r].n; n++) begin
        @(negedge clk); k++; chk++;
        if (dut_state() !== exp_state()) begin err++; $display("FAIL wrap_model cyc=%0d got %h want %h", k, dut_state(), exp_state()); end
        wc0 += int'(wrp[0]); wc1 += int'(wrp[1]);
      end
      snap[r] = cnt;
    end
    chk++; if (snap[3][0] !== 4'd0) begin err++; $display("FAIL wrap_up got %0d want 0", snap[3][0]); end
    chk++; if (snap[3][1] !== 4'd9) begin err++; $display("FAIL sat_up got %0d want 9", snap[3][1]); end
    chk++; if (snap[5][0] !== 4'd9) begin err++; $display("FAIL wrap_down got %0d want 9", snap[5][0]); end
    chk++; if (snap[9][1] !== 4'd0) begin err++; $display("FAIL sat_down got %0d want 0", snap[9][1]); end
    chk++; if (wc0 != 3) begin err++; $display("FAIL wrap_pulses got %0d want 3", wc0); end
    chk++; if (wc1 != 0) begin err++; $display("FAIL sat_wrap_pulses got %0d want 0", wc1); end
  endtask

  task automatic test_debounce();
    row_t seq[6] = '{'{0,0,1,0,4'd0,1}, '{0,0,0,0,4'd0,3}, '{1,0,0,0,4'd0,3},
                     '{0,0,0,0,4'd0,12}, '{1,0,0,0,4'd0,10}, '{0,0,0,0,4'd0,10}};
    logic [3:0] after_glitch = 4'hf;
    int lat = 0, k = 0;
    foreach (seq[r]) begin
      apply(seq[r]);
      for (int n = 0; n < seq[r].n; n++) begin
        @(negedge clk); k++; chk++;
        if (dut_state() !== exp_state()) begin err++; $display("FAIL debounce_model cyc=%0d got %h want %h", k, dut_state(), exp_state()); end
        if (r == 4 && lat == 0 && cnt[2] != 4'd0) lat = n + 1;
      end
      if (r == 3) after_glitch = cnt[2];
    end
    chk++; if (after_glitch !== 4'd0) begin err++; $display("FAIL debounce_glitch got %0d want 0", after_glitch); end
    chk++; if (lat != 7) begin err++; $display("FAIL debounce_latency got %0d want 7", lat); end
    chk++; if (cnt[2] !== 4'd1) begin err++; $display("FAIL debounce_final got %0d want 1", cnt[2]); end
  endtask

  task automatic test_cancel();
    row_t seq[12] = '{'{0,0,0,1,4'd5,1}, '{0,0,0,0,4'd0,3}, '{1,1,0,0,4'd0,5}, '{0,0,0,0,4'd0,12},
                      '{0,0,0,1,4'd12,1}, '{0,0,0,0,4'd0,2}, '{0,0,1,0,4'd0,1}, '{0,0,0,0,4'd0,2},
                      '{1,0,0,0,4'd0,2}, '{1,0,1,0,4'd0,1}, '{1,0,0,0,4'd0,4}, '{0,0,0,0,4'd0,12}};
    logic [2:0][3:0] snap[12];
    int k = 0;
    foreach (seq[r]) begin
      apply(seq[r]);
      for (int n = 0; n < seq[r].n; n++) begin
        @(negedge clk); k++; chk++;
        if (dut_state() !== exp_state()) begin err++; $display("FAIL cancel_model cyc=%0d got %h want %h", k, dut_state(), exp_state()); end
      end
      snap[r] = cnt;
    end
    chk++; if (snap[3] !== {4'd5, 4'd5, 4'd5}) begin err++; $display("FAIL cancel_same_cycle got %h want 555", snap[3]); end
    chk++; if (snap[5] !== {4'd9, 4'd9, 4'd9}) begin err++; $display("FAIL load_clamp got %h want 999", snap[5]); end
    chk++; if (cnt[0] !== 4'd0) begin err++; $display("FAIL clear_drops_event got %0d want 0", cnt[0]); end
    chk++; if (cnt[2] !== 4'd1) begin err++; $display("FAIL late_event_counts got %0d want 1", cnt[2]); end
  endtask

  task automatic test_reset_mid();
    int lat = 0;
    load = 1'b1; load_val = 4'd5;
    @(negedge clk); load = 1'b0;
    repeat (3) @(negedge clk);
    up = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); chk++;
      if (dut_state() !== exp_state()) begin err++; $display("FAIL reset_mid_pre cyc=%0d got %h want %h", k, dut_state(), exp_state()); end
    end
    #2 rstn = 1'b0;
    #1 chk++;
    if (cnt !== 12'h000 || wrp !== 3'b000 || azero !== 3'b111) begin
      err++; $display("FAIL reset_mid_async got cnt=%h wrap=%b zero=%b want 000/000/111", cnt, wrp, azero);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk); chk++;
      if (dut_state() !== exp_state()) begin err++; $display("FAIL reset_mid_post cyc=%0d got %h want %h", k, dut_state(), exp_state()); end
      if (lat == 0 && cnt[0] != 4'd0) lat = k;
    end
    chk++; if (lat != 3) begin err++; $display("FAIL reset_release_latency got %0d want 3", lat); end
    chk++; if (cnt !== {4'd1, 4'd1, 4'd1}) begin err++; $display("FAIL reset_release_once got %h want 111", cnt); end
    up = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_random();
    int hu = 0, hd = 0;
    for (int k = 0; k < 1500; k++) begin
      if (hu == 0) begin up = 1'($urandom_range(1, 0)); hu = $urandom_range(12, 1); end
      if (hd == 0) begin down = 1'($urandom_range(1, 0)); hd = $urandom_range(12, 1); end
      hu--; hd--;
      clear    = ($urandom_range(39, 0) == 0);
      load     = ($urandom_range(29, 0) == 0);
      load_val = 4'($urandom_range(15, 0));
      @(negedge clk); chk++;
      if (dut_state() !== exp_state()) begin err++; $display("FAIL random_model cyc=%0d got %h want %h", k, dut_state(), exp_state()); end
    end
    up = 1'b0; down = 1'b0; clear = 1'b0; load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap();
    test_debounce();
    test_cancel();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule

// File: doc/event_counter_updown.md
Name: event_counter_updown

Overview:
Parametrised up/down event counter for the display datapath. Counts rising edges on two asynchronous inputs (e.g. push-buttons). Each input is synchronised, debounced and edge-detected before it reaches the counter. Adds the following on top of the single-input edge counter:
- programmable modulo
- wrap or saturate mode
- synchronous clear and load
- boundary flags
Output feeds the display decoder.

Parameters:
- COUNT_WIDTH, 16, counter width in bits (>=2).
- MAX_VALUE, 2**COUNT_WIDTH-1, highest count value; counter range is 0..MAX_VALUE; must be < 2**COUNT_WIDTH.
- SATURATE, 0, boundary mode: 0 = wrap, 1 = saturate at 0 / MAX_VALUE.
- SYNC_STAGES, 2, flip-flops in each input synchroniser (>=2).
- DEBOUNCE_CYCLES, 0, consecutive stable cycles required before a synchronised level is accepted; 0 bypasses the filter.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- up_i  in  1  asynchronous increment request; each rising edge counts +1.
- down_i  in  1  asynchronous decrement request; each rising edge counts -1.
- clear_i  in  1  synchronous clear (already in the clk_i domain).
- load_i  in  1  synchronous load strobe (already in the clk_i domain).
- load_val_i  in  COUNT_WIDTH  value to load.
- count_o  out  COUNT_WIDTH  current count (registered).
- wrap_o  out  1  one-cycle pulse when the count wraps (wrap mode only).
- at_max_o  out  1  count_o == MAX_VALUE (combinational from the count register).
- at_zero_o  out  1  count_o == 0 (combinational from the count register).

Behaviour:
- Reset (rstn_i low, async):
  - count_o = 0, wrap_o = 0.
  - All synchroniser, filter, debounce-counter and edge-detect registers = 0.
  - Consequence: at_zero_o = 1, at_max_o = 0.
- Input path, per input, identical for up and down:
  - SYNC_STAGES-flop chain s[0..N-1] → debounce filter → filt → filt_dly register.
  - Increment/decrement event = filt & ~filt_dly, lasting exactly one cycle.
- Debounce filter (DEBOUNCE_CYCLES = D > 0):
  - Counter is cleared whenever s[N-1] == filt.
  - Counter increments each cycle while s[N-1] != filt.
  - filt <= s[N-1] on the edge where the counter equals D-1 and the inputs still differ; the counter clears on that same edge.
  - Glitches shorter than D cycles at s[N-1] are rejected.
  - D = 0: filt = s[N-1] directly (no register).
- Latency: if up_i is first sampled high on clock edge 1, count_o changes on edge SYNC_STAGES + DEBOUNCE_CYCLES + 1. A held-high input counts once only.
- Counter update priority, per cycle:
  1. clear_i → count = 0.
  2. load_i → count = min(load_val_i, MAX_VALUE).
  3. up event and down event in the same cycle → no change (events cancel).
  4. up event only:
     - count < MAX_VALUE → count + 1.
     - count == MAX_VALUE: wrap mode → 0 and wrap_o = 1 for one cycle; saturate mode → hold.
  5. down event only:
     - count > 0 → count - 1.
     - count == 0: wrap mode → MAX_VALUE and wrap_o = 1; saturate mode → hold.
- Events arriving while clear_i or load_i is active are dropped, not queued.
- wrap_o is registered and high for exactly the cycle after the wrapping edge. It is never asserted in saturate mode or by clear/load.
- All arithmetic is modulo by comparison only; no overflow past MAX_VALUE is ever stored.
- Reset mid-operation: all state returns to reset values immediately.
  - An input held high through reset release produces one event after the normal latency, because filt_dly resets to 0.

Test Plan:
1. COUNT_WIDTH=4, MAX_VALUE=9, SYNC_STAGES=2, DEBOUNCE_CYCLES=0; three 5-cycle up_i pulses → count_o 0→1→2→3; each change occurs exactly 3 edges after the first sampling edge; at_zero_o drops after the first event.
2. Same parameters, wrap mode; from count 9, one up pulse → count_o = 0, wrap_o high for one cycle. From 0, one down pulse → count_o = 9, wrap_o high for one cycle.
3. SATURATE=1, MAX_VALUE=9; at count 9, up pulse → stays 9, at_max_o = 1, wrap_o = 0. At count 0, down pulse → stays 0, wrap_o = 0.
4. DEBOUNCE_CYCLES=4: a 3-cycle up_i glitch → no change. A 10-cycle up_i pulse → exactly +1, landing on edge 2+4+1 = 7 after the first sampling edge.
5. up_i and down_i pulses aligned so their events fall in the same cycle → count unchanged.
   - Then load_i with load_val_i=12, MAX_VALUE=9 → count_o = 9.
   - Then clear_i asserted in the same cycle as an up event → count_o = 0 and the event is dropped.
6. Hold up_i high; assert rstn_i low mid-count → count_o = 0 immediately. Release reset with up_i still high → exactly one increment after 3 edges, and none after that.
